eight_to_six_narrow: RTL and testbench
======================================

EIGHT_TO_SIX_NARROW -- requirements
Module: eight_to_six_narrow

Interface
REQ-001 The block SHALL have parameter SATURATE, default 1: 1 clamps out-of-range values to 6'h3F, 0 truncates to in_data[5:0].
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1: in_data holds a valid operand.
REQ-005 The block SHALL have port in_data, input, 8: unsigned operand to narrow.
REQ-006 The block SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-007 The block SHALL have port out_valid, output, 1: out_data and out_ovf are valid.
REQ-008 The block SHALL have port out_data, output, 6: narrowed unsigned result.
REQ-009 The block SHALL have port out_ovf, output, 1: out_data's source had in_data[7:6] != 0.
REQ-010 The block SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-011 The block SHALL have port clr_count, input, 1: synchronous clear of ovf_count.
REQ-012 The block SHALL have port ovf_count, output, 8: saturating count of accepted overflowing operands.

Function
REQ-013 The block SHALL implement a two-state FSM, EMPTY (no result held) and FULL (result held).
REQ-014 The block SHALL drive in_ready = rst_n && (state==EMPTY || out_ready), combinationally.
REQ-015 An accept SHALL occur when in_valid && in_ready; a drain SHALL occur when out_valid && out_ready.
REQ-016 Latency SHALL be one cycle: an operand accepted at edge N appears on out_data with out_valid=1 after edge N.
REQ-017 If in_data[7:6]==2'b00, the result SHALL be out_data=in_data[5:0], out_ovf=0.
REQ-018 Otherwise the result SHALL be out_ovf=1, with out_data=6'h3F if SATURATE=1, else in_data[5:0].
REQ-019 Transitions: EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with simultaneous accept (new result loaded, no bubble).
REQ-020 While FULL and out_ready=0, out_data, out_ovf and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-021 out_valid SHALL equal (state==FULL).
REQ-022 ovf_count SHALL increment by 1 on each accept whose operand has in_data[7:6]!=0, saturating at 8'hFF.
REQ-023 If clr_count=1, ovf_count SHALL become 0 at the next edge regardless of a simultaneous overflowing accept (clear wins).
REQ-024 in_valid without in_ready SHALL have no effect on any state.

Reset
REQ-025 While rst_n=0 at a rising edge, state SHALL become EMPTY, out_data 6'h00, out_ovf 0, ovf_count 8'h00.
REQ-026 While rst_n=0, in_ready SHALL be 0; a result held mid-transfer SHALL be discarded.
REQ-027 The first accept SHALL be possible at the first edge with rst_n=1.

Structure
REQ-028 Shared package mini_alu_pkg SHALL hold constants IN_W=8, OUT_W=6, CNT_W=8 and the FSM state enum (EMPTY, FULL).
REQ-029 Narrowing (REQ-017/018) SHALL be a combinational sub-module six_bit_sat_narrow, parameterised by SATURATE; the FSM, output register and counter stay in eight_to_six_narrow.

Verification
REQ-030 The bench SHALL cover in-range: in_data=8'h2A, out_ready=1 -> next cycle out_data=6'h2A, out_ovf=0, ovf_count=0.
REQ-031 The bench SHALL cover saturation: SATURATE=1, in_data=8'hC5 -> out_data=6'h3F, out_ovf=1, ovf_count=1; SATURATE=0 -> out_data=6'h05, out_ovf=1.
REQ-032 The bench SHALL cover backpressure: accept 8'h11, hold out_ready=0 for 3 cycles -> out_data stable at 6'h11, in_ready=0; then out_ready=1 with in_valid=1 and in_data=8'h22 -> 6'h22 next cycle with no bubble.
REQ-033 The bench SHALL cover counter saturation and clear: 300 accepted operands of 8'h80 -> ovf_count=8'hFF; clr_count=1 together with an overflowing accept -> ovf_count=0.
REQ-034 The bench SHALL cover reset mid-operation: FULL with out_ready=0, rst_n=0 for one edge -> out_valid=0, out_data=0, ovf_count=0, in_ready=0 during reset.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// Shared constants, FSM state encoding and result type for the narrowing datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mini_alu_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 6;
  localparam int CNT_W = 8;

  // EMPTY: no result held; FULL: a result waits for downstream.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Narrowed value together with its overflow flag.
  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] dat;
  } narrow_t;

endpackage

// File: rtl/six_bit_sat_narrow.sv
// Narrows an 8-bit unsigned operand to 6 bits, clamping or truncating on overflow.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing block decides when the result is captured.
module six_bit_sat_narrow
  import mini_alu_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  // Any set bit above the 6-bit range is an overflow; clamp to all-ones or keep low bits.
  always_comb begin
    out_ovf  = |in_data[IN_W-1:OUT_W];
    out_data = in_data[OUT_W-1:0];
    if (out_ovf && (SATURATE != 0)) begin
      out_data = {OUT_W{1'b1}};
    end
  end

endmodule

// File: rtl/eight_to_six_narrow.sv
// Registered 8-to-6 bit narrowing stage with a saturating overflow counter.
// Latency: one cycle from accept to out_valid.
// Backpressure: single-entry skid-free holding register; in_ready follows out_ready while FULL, so drain and refill happen in the same cycle.
module eight_to_six_narrow
  import mini_alu_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  state_t  state;
  state_t  state_nxt;
  narrow_t nar;
  logic    accept;
  logic    drain;

  six_bit_sat_narrow #(
    .SATURATE (SATURATE)
  ) u_narrow (
    .in_data  (in_data),
    .out_data (nar.dat),
    .out_ovf  (nar.ovf)
  );

  // Ready is forced low during reset so nothing is taken while the stage is being cleared.
  assign in_ready  = rst_n && ((state == EMPTY) || out_ready);
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Next state: fill on accept, empty only when draining without a refill.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Result register loads only on accept, so it holds stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      out_data <= nar.dat;
      out_ovf  <= nar.ovf;
    end
  end

  // Overflow counter saturates at all-ones; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (accept && nar.ovf && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eight_to_six_narrow.sv
// Self-checking bench: directed literal cases plus randomized traffic against a behavioural model.
// Two instances (clamping and truncating) share all stimulus.
// Model updates on posedge, compares run on negedge, stimulus changes 2 time units after posedge.
module tb_eight_to_six_narrow;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       clr_count;

  logic       in_ready_s1, out_valid_s1, out_ovf_s1;
  logic [5:0] out_data_s1;
  logic [7:0] ovf_count_s1;
  logic       in_ready_s0, out_valid_s0, out_ovf_s0;
  logic [5:0] out_data_s0;
  logic [7:0] ovf_count_s0;

  int checks   = 0;
  int failures = 0;

  eight_to_six_narrow #(.SATURATE(1)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_s1),
    .out_valid (out_valid_s1),
    .out_data  (out_data_s1),
    .out_ovf   (out_ovf_s1),
    .out_ready (out_ready),
    .clr_count (clr_count),
    .ovf_count (ovf_count_s1)
  );

  eight_to_six_narrow #(.SATURATE(0)) dut_trunc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_s0),
    .out_valid (out_valid_s0),
    .out_data  (out_data_s0),
    .out_ovf   (out_ovf_s0),
    .out_ready (out_ready),
    .clr_count (clr_count),
    .ovf_count (ovf_count_s0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit      m_known = 1'b0;  // set once a reset edge has defined the DUT state
  bit      m_full  = 1'b0;  // a result is waiting downstream
  int      m_raw   = 0;     // last accepted operand (0 after reset)
  int      m_cnt   = 0;     // overflow count

  function automatic int exp_data(input int raw, input bit sat);
    if (raw < 64) return raw;
    return sat ? 63 : (raw % 64);
  endfunction

  function automatic bit exp_ready();
    return rst_n && (!m_full || out_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_raw   = 0;
      m_cnt   = 0;
    end else begin
      if (in_valid && exp_ready()) begin
        m_full = 1'b1;
        m_raw  = int'(in_data);
        if (m_raw >= 64 && m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      if (clr_count) m_cnt = 0;
    end
  end

  // Compare both instances against the model on every cycle once state is defined.
  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready_sat",    32'(in_ready_s1),  32'(exp_ready()));
      chk("in_ready_trunc",  32'(in_ready_s0),  32'(exp_ready()));
      chk("out_valid_sat",   32'(out_valid_s1), 32'(m_full));
      chk("out_valid_trunc", 32'(out_valid_s0), 32'(m_full));
      chk("out_data_sat",    32'(out_data_s1),  32'(exp_data(m_raw, 1'b1)));
      chk("out_data_trunc",  32'(out_data_s0),  32'(exp_data(m_raw, 1'b0)));
      chk("out_ovf_sat",     32'(out_ovf_s1),   32'(m_raw >= 64));
      chk("out_ovf_trunc",   32'(out_ovf_s0),   32'(m_raw >= 64));
      chk("ovf_count_sat",   32'(ovf_count_s1), 32'(m_cnt));
      chk("ovf_count_trunc", 32'(ovf_count_s0), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr_count = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    chk("reset_valid", 32'(out_valid_s1), 32'd0);
    chk("reset_ready", 32'(in_ready_s1), 32'd0);
    rst_n = 1'b1;

    // In-range operand passes straight through.
    drive(1'b1, 8'h2A, 1'b1, 1'b0);
    tick();
    chk("inrange_valid", 32'(out_valid_s1), 32'd1);
    chk("inrange_data",  32'(out_data_s1),  32'h2A);
    chk("inrange_ovf",   32'(out_ovf_s1),   32'd0);
    chk("inrange_count", 32'(ovf_count_s1), 32'd0);

    // Overflowing operand: clamp vs truncate.
    drive(1'b1, 8'hC5, 1'b1, 1'b0);
    tick();
    chk("sat_data",    32'(out_data_s1),  32'h3F);
    chk("sat_ovf",     32'(out_ovf_s1),   32'd1);
    chk("sat_count",   32'(ovf_count_s1), 32'd1);
    chk("trunc_data",  32'(out_data_s0),  32'h05);
    chk("trunc_ovf",   32'(out_ovf_s0),   32'd1);

    // Drain, then backpressure with a held result.
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data",  32'(out_data_s1),  32'h11);
      chk("bp_hold_valid", 32'(out_valid_s1), 32'd1);
      chk("bp_in_ready",   32'(in_ready_s1),  32'd0);
    end
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    #1;
    chk("bp_refill_ready", 32'(in_ready_s1), 32'd1);
    tick();
    chk("bp_nobubble_valid", 32'(out_valid_s1), 32'd1);
    chk("bp_nobubble_data",  32'(out_data_s1),  32'h22);

    // Counter saturation then clear winning over an overflowing accept.
    drive(1'b1, 8'h80, 1'b1, 1'b0);
    repeat (300) tick();
    chk("cnt_saturated", 32'(ovf_count_s1), 32'hFF);
    drive(1'b1, 8'h80, 1'b1, 1'b1);
    tick();
    chk("cnt_clear_wins", 32'(ovf_count_s1), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();

    // Reset while FULL and stalled.
    drive(1'b1, 8'h15, 1'b0, 1'b0);
    tick();
    chk("pre_reset_full", 32'(out_valid_s1), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_s1), 32'd0);
    tick();
    chk("rst_valid", 32'(out_valid_s1), 32'd0);
    chk("rst_data",  32'(out_data_s1),  32'd0);
    chk("rst_count", 32'(ovf_count_s1), 32'd0);
    chk("rst_in_ready_after_edge", 32'(in_ready_s1), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    #1;
    chk("first_edge_ready", 32'(in_ready_s1), 32'd1);
    tick();
    chk("first_accept_valid", 32'(out_valid_s1), 32'd1);
    chk("first_accept_data",  32'(out_data_s1),  32'h07);

    // Randomized traffic, checked every cycle by the model comparator.
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0,
            8'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0);
      tick();
    end

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
